// File: rtl/fifo8x9_stream_ctrl.sv
// fifo8x9_stream_ctrl: access controller for a pointer-driven 256x9 FIFO array.
// Turns valid/ready streams into wren/rden pulses, tracks array occupancy and
// re-times the array's one-cycle read latency through a 2-entry skid buffer.
module fifo8x9_stream_ctrl #(
  parameter int unsigned DATA_W = 9,
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned DEPTH  = 256
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [DATA_W-1:0] s_data,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [DATA_W-1:0] m_data,
  output logic              wren,
  output logic              WrInc,
  output logic [DATA_W-1:0] fifo_din,
  output logic              rden,
  output logic              RdInc,
  input  logic [DATA_W-1:0] fifo_dout,
  output logic              RdPtrClr,
  output logic              WrPtrClr,
  output logic [ADDR_W:0]   count,
  output logic              full,
  output logic              empty
);

  localparam int unsigned CNT_W = ADDR_W + 1;

  typedef enum logic {ST_CLR = 1'b0, ST_RUN = 1'b1} state_t;

  state_t              state_q;
  state_t              state_d;
  logic [CNT_W-1:0]    count_q;
  logic                inflight_q;
  logic [1:0]          buf_cnt_q;
  logic [DATA_W-1:0]   buf0_q;
  logic [DATA_W-1:0]   buf1_q;

  logic                run_c;
  logic                pop_c;
  logic [2:0]          occ_c;

  // Handshake terms shared by the output logic and the datapath
  always_comb begin
    run_c = (state_q == ST_RUN) && !rst && !flush;
    pop_c = (buf_cnt_q != 2'd0) && m_ready;
    occ_c = 3'(buf_cnt_q) + 3'(inflight_q) - 3'(pop_c);
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_CLR;
    else     state_q <= state_d;
  end

  // Next state: one pointer-clear cycle, then run until flushed
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_CLR:  state_d = ST_RUN;
      ST_RUN:  if (flush) state_d = ST_CLR;
      default: state_d = ST_CLR;
    endcase
  end

  // FSM outputs: pointer clears, write accept and read issue
  always_comb begin
    RdPtrClr = 1'b0;
    WrPtrClr = 1'b0;
    s_ready  = 1'b0;
    rden     = 1'b0;
    if (state_q == ST_CLR && !rst) begin
      RdPtrClr = 1'b1;
      WrPtrClr = 1'b1;
    end
    if (run_c) begin
      s_ready = (count_q != CNT_W'(DEPTH));
      rden    = (count_q != CNT_W'(0)) && (occ_c < 3'd2);
    end
    wren     = s_valid && s_ready;
    WrInc    = wren;
    RdInc    = rden;
    fifo_din = s_data;
  end

  // Occupancy, read-in-flight flag and skid buffer
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      count_q    <= '0;
      inflight_q <= 1'b0;
      buf_cnt_q  <= 2'd0;
      if (rst) begin
        buf0_q <= '0;
        buf1_q <= '0;
      end
    end else begin
      count_q    <= count_q + CNT_W'(wren) - CNT_W'(rden);
      inflight_q <= rden;
      case ({inflight_q, pop_c})
        2'b10: begin
          if (buf_cnt_q == 2'd0) buf0_q <= fifo_dout;
          else                   buf1_q <= fifo_dout;
          buf_cnt_q <= buf_cnt_q + 2'd1;
        end
        2'b01: begin
          buf0_q    <= buf1_q;
          buf_cnt_q <= buf_cnt_q - 2'd1;
        end
        2'b11: begin
          if (buf_cnt_q == 2'd1) begin
            buf0_q <= fifo_dout;
          end else begin
            buf0_q <= buf1_q;
            buf1_q <= fifo_dout;
          end
        end
        default: ;
      endcase
    end
  end

  // Status derived from registered state
  always_comb begin
    count   = count_q;
    full    = (count_q == CNT_W'(DEPTH));
    empty   = (count_q == CNT_W'(0)) && !inflight_q && (buf_cnt_q == 2'd0);
    m_valid = (buf_cnt_q != 2'd0);
    m_data  = buf0_q;
  end

endmodule

// File: tb/tb_fifo8x9_stream_ctrl.sv
// Bench for fifo8x9_stream_ctrl: behavioural 256x9 array model, scoreboard
// queue filled on accepted writes and drained by a monitor on each output pop.
module tb_fifo8x9_stream_ctrl;

  logic       clk = 1'b0;
  logic       rst, flush, s_valid, m_ready;
  logic       s_ready, m_valid, wren, WrInc, rden, RdInc, RdPtrClr, WrPtrClr, full, empty;
  logic [8:0] s_data, m_data, fifo_din, count;
  wire  [8:0] fifo_dout;

  int checks = 0;
  int errors = 0;
  logic [8:0] exp_q[$];

  always #5 clk = ~clk;

  fifo8x9_stream_ctrl dut (
    .clk(clk), .rst(rst), .flush(flush),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
    .wren(wren), .WrInc(WrInc), .fifo_din(fifo_din),
    .rden(rden), .RdInc(RdInc), .fifo_dout(fifo_dout),
    .RdPtrClr(RdPtrClr), .WrPtrClr(WrPtrClr),
    .count(count), .full(full), .empty(empty)
  );

  // Storage array model: pointer clears, registered read data, Z when idle
  logic [8:0] mem [256];
  logic [7:0] wp = 8'd0;
  logic [7:0] rp = 8'd0;
  logic       dv = 1'b0;
  logic [8:0] dq = 9'd0;
  always @(posedge clk) begin
    if (WrPtrClr) wp <= 8'd0;
    else if (WrInc) begin mem[wp] <= fifo_din; wp <= wp + 8'd1; end
    if (RdPtrClr) rp <= 8'd0;
    else if (RdInc) rp <= rp + 8'd1;
    dv <= rden;
    dq <= mem[rp];
  end
  assign fifo_dout = dv ? dq : 9'bz;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: output order against the scoreboard, plus per-cycle invariants
  always @(negedge clk) begin
    if (!rst) begin
      chk("wrinc_eq_wren", WrInc, wren);
      chk("rdinc_eq_rden", RdInc, rden);
      if (rden) chk("rden_at_count0", 32'(count == 9'd0), 0);
      if (m_valid && m_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_word: got %0h expected none at %0t", m_data, $time);
        end else begin
          chk("m_data_order", m_data, exp_q.pop_front());
        end
      end
      if (s_valid && s_ready) begin
        chk("wren_on_accept", wren, 1);
        chk("fifo_din", fifo_din, s_data);
        exp_q.push_back(s_data);
      end
      if (flush) exp_q.delete();
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  task automatic drain(input int limit);
    bit done = 1'b0;
    m_ready = 1'b1;
    s_valid = 1'b0;
    for (int i = 0; i < limit && !done; i++) begin
      step();
      smp();
      if (empty && !m_valid) done = 1'b1;
    end
    chk("drain_done", 32'(done), 1);
    chk("drain_count", count, 0);
    chk("drain_sb_empty", exp_q.size(), 0);
  endtask

  // Offer words base+k until n are accepted; returns number accepted
  task automatic stream(input int n, input int mul, input int add, input bit rnd, output int got);
    got = 0;
    for (int i = 0; i < 20 * n + 600 && got < n; i++) begin
      step();
      s_valid = 1'b1;
      s_data  = 9'(got * mul + add);
      if (rnd) m_ready = ($urandom_range(0, 3) != 0);
      smp();
      if (s_ready) got++;
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int got;
    rst = 1'b1; flush = 1'b0; s_valid = 1'b0; m_ready = 1'b0; s_data = 9'd0;

    // Reset and pointer-clear pulse
    repeat (2) @(posedge clk);
    smp();
    chk("rst_rdclr", RdPtrClr, 0);
    chk("rst_wrclr", WrPtrClr, 0);
    chk("rst_empty", empty, 1);
    chk("rst_count", count, 0);
    chk("rst_mvalid", m_valid, 0);
    chk("rst_sready", s_ready, 0);
    step(); rst = 1'b0;
    smp();
    chk("clr_rdclr", RdPtrClr, 1);
    chk("clr_wrclr", WrPtrClr, 1);
    chk("clr_sready", s_ready, 0);
    step(); smp();
    chk("run_rdclr", RdPtrClr, 0);
    chk("run_sready", s_ready, 1);
    chk("run_empty", empty, 1);

    // Three words with m_ready high: 3-cycle first-word latency
    m_ready = 1'b1;
    step(); s_valid = 1'b1; s_data = 9'h001; smp();
    chk("t2_accept", s_ready, 1);
    step(); s_data = 9'h0AA; smp();
    chk("t2_lat1", m_valid, 0);
    step(); s_data = 9'h1FF; smp();
    chk("t2_lat2", m_valid, 0);
    step(); s_valid = 1'b0; smp();
    chk("t2_lat3", m_valid, 1);
    chk("t2_first", m_data, 9'h001);
    drain(50);
    chk("t2_empty", empty, 1);

    // Fill to full with m_ready low
    m_ready = 1'b0;
    stream(258, 1, 0, 1'b0, got);
    chk("t3_accepted", got, 258);
    step(); s_data = 9'h102; smp();
    chk("t3_full", full, 1);
    chk("t3_sready", s_ready, 0);
    chk("t3_count", count, 256);
    chk("t3_mvalid", m_valid, 1);
    chk("t3_head", m_data, 9'h000);
    chk("t3_refused", wren, 0);

    // Single pop at full: read proceeds, refill next cycle
    step(); m_ready = 1'b1; smp();
    chk("t4_rden", rden, 1);
    chk("t4_count_hold", count, 256);
    chk("t4_wren0", wren, 0);
    step(); m_ready = 1'b0; smp();
    chk("t4_wren1", wren, 1);
    chk("t4_count255", count, 255);
    step(); s_valid = 1'b0; smp();
    chk("t4_count256", count, 256);
    chk("t4_full", full, 1);
    drain(2000);

    // 600 words with random consumer: pointers wrap
    stream(600, 7, 3, 1'b1, got);
    chk("t5_accepted", got, 600);
    drain(2000);

    // Flush with a read in flight and 10 words stored
    m_ready = 1'b0;
    stream(12, 1, 9'h100, 1'b0, got);
    chk("t6_accepted", got, 12);
    step(); s_data = 9'h10C; m_ready = 1'b1; smp();
    chk("t6_rden", rden, 1);
    step(); s_valid = 1'b0; m_ready = 1'b0; flush = 1'b1; smp();
    chk("t6_count10", count, 10);
    chk("t6_flush_sready", s_ready, 0);
    chk("t6_flush_rden", rden, 0);
    step(); flush = 1'b0; smp();
    chk("t6_count0", count, 0);
    chk("t6_mvalid", m_valid, 0);
    chk("t6_rdclr", RdPtrClr, 1);
    chk("t6_wrclr", WrPtrClr, 1);
    chk("t6_sready0", s_ready, 0);
    step(); smp();
    chk("t6_rdclr_off", RdPtrClr, 0);
    chk("t6_sready1", s_ready, 1);
    m_ready = 1'b1;
    stream(3, 1, 9'h0F0, 1'b0, got);
    chk("t6_post_accepted", got, 3);
    drain(50);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
